// File: rtl/ysyx_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner codes
// and the two-way round-robin pick used when both masters ask in the same cycle.
package ysyx_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_IFU = 1'b0,
        ARB_LSU = 1'b1
    } arb_owner_e;

    // On a tie the master that did not own the bus last time wins.
    function automatic arb_owner_e arb_pick(input logic i_ifu, input logic i_lsu,
                                            input arb_owner_e i_last);
        if (i_ifu && i_lsu) begin
            return (i_last == ARB_IFU) ? ARB_LSU : ARB_IFU;
        end else if (i_lsu) begin
            return ARB_LSU;
        end else begin
            return ARB_IFU;
        end
    endfunction

endpackage

// File: rtl/ysyx_mem_arbiter.sv
// Two-master (IFU fetch / LSU load-store) to one-slave memory arbiter: one whole
// transaction at a time, round-robin on contention, watchdog-protected response wait.
module ysyx_mem_arbiter
    import ysyx_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic                  ifu_rvalid,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_req,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_rvalid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_gnt,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  bus_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    arb_owner_e             r_owner;
    arb_owner_e             r_last_grant;
    arb_owner_e             w_pick;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_wen;
    logic [DATA_W-1:0]      r_wdata;
    logic [STRB_W-1:0]      r_wstrb;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic                   r_bus_err;

    logic                   w_any_req;
    logic                   w_sat;
    logic                   w_resp;
    logic                   w_timeout;
    logic                   w_grant;
    logic                   w_in_req;
    logic                   w_done;
    logic [DATA_W-1:0]      w_rdata;

    assign w_any_req = ifu_arvalid | lsu_req;
    assign w_sat     = (r_cnt == CNT_MAX);
    assign w_pick    = arb_pick(ifu_arvalid, lsu_req, r_last_grant);

    always_comb begin
        w_state_nxt = r_state;
        w_resp      = 1'b0;
        w_timeout   = 1'b0;
        w_grant     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (mem_gnt) begin
                    w_grant = 1'b1;
                    if (mem_rvalid) begin
                        w_resp      = 1'b1;
                        w_state_nxt = ARB_IDLE;
                    end else begin
                        w_state_nxt = ARB_WAIT;
                    end
                end else if (w_sat) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid) begin
                    w_resp      = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end else if (w_sat) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_owner      <= ARB_IFU;
            r_last_grant <= ARB_IFU;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_cnt        <= '0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB_IDLE && w_any_req) begin
                r_owner <= w_pick;
                r_cnt   <= '0;
                if (w_pick == ARB_LSU) begin
                    r_addr  <= lsu_addr;
                    r_wen   <= lsu_wen;
                    r_wdata <= lsu_wdata;
                    r_wstrb <= lsu_wstrb;
                end else begin
                    r_addr  <= ifu_araddr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                    r_wstrb <= '0;
                end
            end else if (r_state == ARB_REQ || r_state == ARB_WAIT) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_grant) begin
                r_last_grant <= r_owner;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Outputs are forced low while rst is high so an abandoned transaction never leaks a pulse.
    assign w_in_req  = (r_state == ARB_REQ) && !rst;
    assign mem_req   = w_in_req;
    assign mem_addr  = w_in_req ? r_addr  : '0;
    assign mem_wen   = w_in_req ? r_wen   : 1'b0;
    assign mem_wdata = w_in_req ? r_wdata : '0;
    assign mem_wstrb = w_in_req ? r_wstrb : '0;

    assign w_done     = (w_resp || w_timeout) && !rst;
    assign w_rdata    = w_timeout ? '0 : mem_rdata;
    assign ifu_rvalid = w_done && (r_owner == ARB_IFU);
    assign lsu_rvalid = w_done && (r_owner == ARB_LSU);
    assign ifu_rdata  = ifu_rvalid ? w_rdata : '0;
    assign lsu_rdata  = (lsu_rvalid && !r_wen) ? w_rdata : '0;
    assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed bench for ysyx_mem_arbiter: single-master reads/writes, round-robin,
// same-cycle grant+response, watchdog timeout and reset during a pending response.
module tb_ysyx_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ifu_araddr = '0;
    logic        ifu_arvalid = 1'b0;
    logic [31:0] ifu_rdata;
    logic        ifu_rvalid;
    logic [31:0] lsu_addr = '0;
    logic        lsu_req = 1'b0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        bus_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_addr(lsu_addr), .lsu_req(lsu_req), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ifu_araddr = '0; ifu_arvalid = 1'b0;
        lsu_addr = '0; lsu_req = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
        mem_gnt = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at negedge+1 of the first cycle mem_req is seen.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    bit ok;
    int k;
    bit exp_lsu;

    initial begin
        // reset values
        reset_dut();
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_mem_addr", mem_addr, 0);

        // IFU fetch, grant after 2 cycles in REQ, response one cycle later
        @(negedge clk);
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        #1 chk("s1_req_registered", mem_req, 0);
        @(negedge clk);
        #1;
        chk("s1_req", mem_req, 1);
        chk("s1_addr", mem_addr, 32'h8000_0000);
        chk("s1_wen", mem_wen, 0);
        chk("s1_wstrb", mem_wstrb, 0);
        @(negedge clk);
        mem_gnt = 1'b1;
        #1 chk("s1_req_hold", mem_req, 1);
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
        #1;
        chk("s1_ifu_rvalid", ifu_rvalid, 1);
        chk("s1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("s1_lsu_rvalid", lsu_rvalid, 0);
        chk("s1_wait_no_req", mem_req, 0);
        @(negedge clk);
        mem_rvalid = 1'b0; ifu_arvalid = 1'b0;
        #1 chk("s1_pulse_1cyc", ifu_rvalid, 0);

        // LSU write
        @(negedge clk);
        lsu_addr = 32'h8000_0100; lsu_req = 1'b1; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        @(negedge clk);
        #1;
        chk("s2_req", mem_req, 1);
        chk("s2_wen", mem_wen, 1);
        chk("s2_addr", mem_addr, 32'h8000_0100);
        chk("s2_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("s2_wstrb", mem_wstrb, 4'hF);
        @(negedge clk);
        #1 chk("s2_addr_stable", mem_addr, 32'h8000_0100);
        @(negedge clk);
        mem_gnt = 1'b1;
        #1 chk("s2_wdata_at_gnt", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("s2_lsu_rvalid", lsu_rvalid, 1);
        chk("s2_lsu_ack_data", lsu_rdata, 0);
        chk("s2_ifu_rvalid", ifu_rvalid, 0);
        @(negedge clk);
        mem_rvalid = 1'b0; lsu_req = 1'b0; lsu_wen = 1'b0;
        #1 chk("s2_pulse_1cyc", lsu_rvalid, 0);

        // both masters request continuously: LSU, IFU, LSU, IFU
        reset_dut();
        ifu_araddr = 32'h0000_1000; ifu_arvalid = 1'b1;
        lsu_addr = 32'h0000_2000; lsu_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_lsu = (t % 2 == 0);
            wait_req(ok);
            chk("rr_req_seen", ok, 1);
            chk("rr_addr", mem_addr, exp_lsu ? 32'h0000_2000 : 32'h0000_1000);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA0 + t;
            #1;
            chk("rr_lsu_rvalid", lsu_rvalid, exp_lsu);
            chk("rr_ifu_rvalid", ifu_rvalid, !exp_lsu);
            chk("rr_rdata", exp_lsu ? lsu_rdata : ifu_rdata, 32'hA0 + t);
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (t == 3) begin
                ifu_arvalid = 1'b0; lsu_req = 1'b0;
            end
        end

        // grant and response in the same cycle
        reset_dut();
        lsu_addr = 32'h0000_3000; lsu_req = 1'b1;
        wait_req(ok);
        chk("sc_req_seen", ok, 1);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        chk("sc_lsu_rvalid", lsu_rvalid, 1);
        chk("sc_lsu_rdata", lsu_rdata, 32'hCAFE_0001);
        @(negedge clk);
        lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        ifu_araddr = 32'h0000_3004; ifu_arvalid = 1'b1;
        #1 chk("sc_idle_no_pulse", lsu_rvalid, 0);
        @(negedge clk);
        #1;
        chk("sc_next_req", mem_req, 1);
        chk("sc_next_addr", mem_addr, 32'h0000_3004);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55;
        #1 chk("sc_ifu_rvalid", ifu_rvalid, 1);
        @(negedge clk);
        ifu_arvalid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        // stray response while idle must be ignored
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h99;
        #1 chk("stray_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;

        // slave never grants: watchdog fires 255 cycles after mem_req rises
        reset_dut();
        ifu_araddr = 32'h0000_4000; ifu_arvalid = 1'b1;
        wait_req(ok);
        chk("to_req_seen", ok, 1);
        k = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            k++;
            if (ifu_rvalid) break;
        end
        chk("to_cycles", k, 255);
        chk("to_ifu_rvalid", ifu_rvalid, 1);
        chk("to_rdata_zero", ifu_rdata, 0);
        chk("to_lsu_rvalid", lsu_rvalid, 0);
        @(negedge clk);
        ifu_arvalid = 1'b0;
        #1;
        chk("to_bus_err", bus_err, 1);
        chk("to_pulse_1cyc", ifu_rvalid, 0);
        lsu_addr = 32'h0000_5000; lsu_req = 1'b1;
        wait_req(ok);
        chk("to_next_req", ok, 1);
        chk("to_next_addr", mem_addr, 32'h0000_5000);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        chk("to_next_rvalid", lsu_rvalid, 1);
        chk("to_next_rdata", lsu_rdata, 32'h0BAD_F00D);
        chk("to_err_sticky", bus_err, 1);
        @(negedge clk);
        lsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;

        // reset while waiting for the response
        @(negedge clk);
        lsu_addr = 32'h0000_6000; lsu_req = 1'b1;
        wait_req(ok);
        chk("rw_req_seen", ok, 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1; lsu_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        #1;
        chk("rw_in_rst_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
        chk("rw_in_rst_req", mem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rw_after_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
        chk("rw_after_rdata", lsu_rdata, 0);
        chk("rw_after_req", mem_req, 0);
        chk("rw_bus_err", bus_err, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
